// File: rtl/pkg_patron.sv
// Shared pattern definition for the baba generator and recognizer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pkg_patron;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        EMITE  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam logic SIMB_A = 1'b0;
    localparam logic SIMB_B = 1'b1;

    localparam int LONG_PATRON_DEF = 4;
    localparam logic [LONG_PATRON_DEF-1:0] PATRON_DEF = {SIMB_B, SIMB_A, SIMB_B, SIMB_A};

endpackage

// File: rtl/cont_simbolo.sv
// Symbol hold counter: counts 0..CICLOS_SIMBOLO-1 while enabled, flags the last cycle.
// Latency: tc is combinational from the count register.
// Backpressure: none; en stalls the count, clr restarts it.
module cont_simbolo #(
    parameter int CICLOS_SIMBOLO = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (CICLOS_SIMBOLO > 1) ? $clog2(CICLOS_SIMBOLO) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CICLOS_SIMBOLO - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gen_patron_baba.sv
// Serial b,a,b,a pattern generator, repeated num_rep times, each symbol held CICLOS_SIMBOLO cycles.
// Latency: first symbol appears one cycle after the accepted inicio edge; all outputs registered.
// Backpressure: none; inicio is ignored (not queued) while ocupado is high.
module gen_patron_baba
    import pkg_patron::*;
#(
    parameter int                     LONG_PATRON    = LONG_PATRON_DEF,
    parameter logic [LONG_PATRON-1:0] PATRON         = PATRON_DEF,
    parameter int                     CICLOS_SIMBOLO = 1,
    parameter int                     ANCHO_REP      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inicio,
    input  logic [ANCHO_REP-1:0] num_rep,
    output logic                 salida,
    output logic                 valido,
    output logic                 ocupado,
    output logic                 fin
);

    localparam int IW = (LONG_PATRON > 1) ? $clog2(LONG_PATRON) : 1;
    localparam logic [IW-1:0] ULT_IDX = IW'(LONG_PATRON - 1);

    estado_t              estado_q, estado_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [ANCHO_REP-1:0] rep_q, rep_d;
    logic [ANCHO_REP-1:0] nrep_q, nrep_d;
    logic                 salida_q, salida_d;
    logic                 valido_q, valido_d;
    logic                 ocupado_q, ocupado_d;
    logic                 fin_q, fin_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    cont_simbolo #(
        .CICLOS_SIMBOLO(CICLOS_SIMBOLO)
    ) u_cont_simbolo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        nrep_d   = nrep_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    nrep_d   = num_rep;
                    idx_d    = '0;
                    rep_d    = '0;
                    cnt_clr  = 1'b1;
                    estado_d = (num_rep == '0) ? FIN : EMITE;
                end
            end
            EMITE: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    if (idx_q == ULT_IDX) begin
                        idx_d = '0;
                        // rep_q never exceeds nrep_q-1, so the counter cannot wrap even at max num_rep
                        if (rep_q == nrep_q - ANCHO_REP'(1)) begin
                            estado_d = FIN;
                        end else begin
                            rep_d = rep_q + ANCHO_REP'(1);
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Outputs are derived from the next state so they land in flops aligned with it
        valido_d  = (estado_d == EMITE);
        salida_d  = valido_d & PATRON[ULT_IDX - idx_d];
        ocupado_d = (estado_d != REPOSO);
        fin_d     = (estado_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            idx_q     <= '0;
            rep_q     <= '0;
            nrep_q    <= '0;
            salida_q  <= 1'b0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            nrep_q    <= nrep_d;
            salida_q  <= salida_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
        end
    end

    assign salida  = salida_q;
    assign valido  = valido_q;
    assign ocupado = ocupado_q;
    assign fin     = fin_q;

endmodule

// File: tb/tb_gen_patron_baba.sv
// Bench for gen_patron_baba: two instances (hold of 1 and 3 cycles) share stimulus;
// a timeline model queues expected symbols and a monitor compares every cycle.
module tb_gen_patron_baba;

    localparam int L = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       inicio  = 1'b0;
    logic [7:0] num_rep = 8'd0;

    logic [1:0] salida;
    logic [1:0] valido;
    logic [1:0] ocupado;
    logic [1:0] fin;

    always #5 clk = ~clk;

    gen_patron_baba u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .inicio (inicio),
        .num_rep(num_rep),
        .salida (salida[0]),
        .valido (valido[0]),
        .ocupado(ocupado[0]),
        .fin    (fin[0])
    );

    gen_patron_baba #(
        .CICLOS_SIMBOLO(3)
    ) u_dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .inicio (inicio),
        .num_rep(num_rep),
        .salida (salida[1]),
        .valido (valido[1]),
        .ocupado(ocupado[1]),
        .fin    (fin[1])
    );

    int cyc       = 0;
    int vs[2]     = '{1, 1};
    int ve[2]     = '{0, 0};
    int fin_at[2] = '{-10, -10};
    bit exp_q [2][$];

    int checks  = 0;
    int errors  = 0;
    bit done    = 1'b0;
    bit timeout = 1'b0;

    function automatic int ciclos(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit idle();
        return (cyc > fin_at[0] + 1) && (cyc > fin_at[1] + 1);
    endfunction

    // Reference timeline: an accepted start at edge e gives valid cycles e..e+N-1 and fin at e+N
    initial begin
        logic [3:0] pat;
        int n;
        int total;
        pat = 4'b1010;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    vs[k]     = 1;
                    ve[k]     = 0;
                    fin_at[k] = -10;
                    exp_q[k].delete();
                end else if (inicio && (cyc >= fin_at[k] + 2)) begin
                    n         = int'(num_rep);
                    total     = n * L * ciclos(k);
                    vs[k]     = cyc;
                    ve[k]     = cyc + total - 1;
                    fin_at[k] = cyc + total;
                    for (int r = 0; r < n; r++)
                        for (int s = 0; s < L; s++)
                            for (int c = 0; c < ciclos(k); c++)
                                exp_q[k].push_back(pat[L-1-s]);
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] cyc=%0d got=%0b expected=%0b", name, k, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic ev, eo, ef, b;
        while (!done) begin
            @(posedge clk or negedge rst_n);
            #3;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    ev = 1'b0; eo = 1'b0; ef = 1'b0;
                end else begin
                    ev = (cyc >= vs[k]) && (cyc <= ve[k]);
                    eo = (cyc >= vs[k]) && (cyc <= fin_at[k]);
                    ef = (cyc == fin_at[k]);
                end
                chk("valido", k, valido[k], ev);
                chk("ocupado", k, ocupado[k], eo);
                chk("fin", k, fin[k], ef);
                if (valido[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL salida_unexpected[inst%0d] cyc=%0d got=%0b expected=no symbol", k, cyc, salida[k]);
                    end else begin
                        b = exp_q[k].pop_front();
                        chk("salida", k, salida[k], b);
                    end
                end else begin
                    chk("salida_idle", k, salida[k], 1'b0);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL symbols_left[inst%0d] got=%0d expected=0", k, exp_q[k].size());
            end
        end
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL drain_timeout got=busy expected=idle within budget");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic pulse(input int n);
        @(negedge clk);
        inicio  = 1'b1;
        num_rep = 8'(n);
        @(negedge clk);
        inicio  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && !idle(); i++) @(negedge clk);
        if (!idle()) timeout = 1'b1;
    endtask

    // Stimulus
    initial begin
        #1 rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            inicio  = ~inicio;
            num_rep = 8'd1;
        end
        @(negedge clk);
        inicio = 1'b0;
        rst_n  = 1'b1;
        wait_cycles(2);

        pulse(1);
        wait_cycles(8);
        pulse(0);
        wait_cycles(4);
        pulse(2);
        wait_cycles(30);

        // Busy: num_rep changed and inicio re-pulsed mid-sequence
        @(negedge clk); inicio = 1'b1; num_rep = 8'd3;
        @(negedge clk); inicio = 1'b0;
        @(negedge clk); num_rep = 8'd9;
        wait_cycles(2);
        @(negedge clk); inicio = 1'b1;
        @(negedge clk); inicio = 1'b0;
        wait_idle(200);
        wait_cycles(3);

        // inicio held high: restarts right after each fin
        @(negedge clk); inicio = 1'b1; num_rep = 8'd1;
        wait_cycles(30);
        inicio = 1'b0;
        wait_idle(200);

        // Asynchronous reset in the middle of a run
        pulse(2);
        wait_cycles(2);
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        pulse(1);
        wait_idle(200);

        pulse(255);
        wait_idle(5000);

        repeat (400) begin
            @(negedge clk);
            inicio  = ($urandom_range(0, 5) == 0);
            num_rep = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        inicio = 1'b0;
        wait_idle(5000);
        wait_cycles(3);
        done = 1'b1;
    end

endmodule
